// File: rtl/legv8_multicycle_core.sv
// Multicycle LEGv8-subset core (ADD/SUB/B/CBZ/LDUR/STUR) over sync-read code and data memories.
// Define RETIRE_TRACE_EN to enable the retire_valid/retire_pc trace; otherwise both are tied to 0.
module legv8_multicycle_core #(
  parameter int DATA_W     = 32,
  parameter int CODE_WORDS = 512,
  parameter int DATA_WORDS = 512,
  parameter int RF_REGS    = 32,
  localparam int PC_W      = $clog2(CODE_WORDS),
  localparam int DADDR_W   = $clog2(DATA_WORDS)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               halted,
  output logic [7:0]         dbg_pc,
  output logic [2:0]         dbg_state,
  output logic               retire_valid,
  output logic [PC_W-1:0]    retire_pc
);
  localparam int RI_W = $clog2(RF_REGS);
  localparam logic [RI_W-1:0] XZR = RI_W'(RF_REGS - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc, pc_next, pc_inc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] opa, opb;
  logic [DATA_W-1:0] rf [RF_REGS];
  logic [DATA_W-1:0] sext9, eff_addr, rf_wdata;
  logic [RI_W-1:0]   rf_waddr;
  logic              rf_we, mem_issue, retire_now;

  function automatic logic is_add(input logic [31:0] w);
    return w[31:21] == 11'b10001011000;
  endfunction
  function automatic logic is_sub(input logic [31:0] w);
    return w[31:21] == 11'b11001011000;
  endfunction
  function automatic logic is_b(input logic [31:0] w);
    return w[31:26] == 6'b000101;
  endfunction
  function automatic logic is_cbz(input logic [31:0] w);
    return w[31:24] == 8'b10110100;
  endfunction
  function automatic logic is_ldur(input logic [31:0] w);
    return w[31:21] == 11'b11111000010;
  endfunction
  function automatic logic is_stur(input logic [31:0] w);
    return w[31:21] == 11'b11111000000;
  endfunction
  function automatic logic [RI_W-1:0] ridx(input logic [4:0] f);
    return f[RI_W-1:0];
  endfunction
  function automatic logic [DATA_W-1:0] rf_read(input logic [RI_W-1:0] i);
    return (i == XZR) ? '0 : rf[i];
  endfunction

  // Branch offsets: truncating the raw immediate equals sign-extend-then-wrap mod CODE_WORDS.
  assign pc_inc    = pc + PC_W'(1);
  assign sext9     = {{(DATA_W-9){ir[20]}}, ir[20:12]};
  assign eff_addr  = opa + sext9;
  assign rf_waddr  = ridx(ir[4:0]);
  assign imem_addr = pc;
  assign dbg_pc    = 8'(pc);
  assign dbg_state = state;
  // Combinational strobe so an asserted reset also suppresses the store in that cycle.
  assign dmem_we   = resetn && (state == S_MEM) && is_stur(ir);

  logic unused_ir;
  assign unused_ir = &{1'b0, ir[11:10]};

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_FETCH;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    rf_we      = 1'b0;
    rf_wdata   = '0;
    mem_issue  = 1'b0;
    retire_now = 1'b0;
    case (state)
      S_FETCH:  if (run) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_add(ir) || is_sub(ir)) begin
          rf_we      = 1'b1;
          rf_wdata   = is_add(ir) ? (opa + opb) : (opa - opb);
          pc_next    = pc_inc;
          state_next = S_FETCH;
          retire_now = 1'b1;
        end else if (is_b(ir)) begin
          pc_next    = pc + PC_W'(ir[25:0]);
          state_next = S_FETCH;
          retire_now = 1'b1;
        end else if (is_cbz(ir)) begin
          pc_next    = (opb == '0) ? (pc + PC_W'(ir[23:5])) : pc_inc;
          state_next = S_FETCH;
          retire_now = 1'b1;
        end else if (is_ldur(ir) || is_stur(ir)) begin
          mem_issue  = 1'b1;
          state_next = S_MEM;
        end else begin
          state_next = S_HALT;
        end
      end
      S_MEM: begin
        if (is_stur(ir)) begin
          pc_next    = pc_inc;
          state_next = S_FETCH;
          retire_now = 1'b1;
        end else begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        rf_wdata   = dmem_rdata;
        pc_next    = pc_inc;
        state_next = S_FETCH;
        retire_now = 1'b1;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc         <= '0;
      ir         <= '0;
      opa        <= '0;
      opb        <= '0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      halted     <= 1'b0;
      for (int i = 0; i < RF_REGS; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (state == S_DECODE) begin
        ir  <= imem_rdata;
        opa <= rf_read(ridx(imem_rdata[9:5]));
        // CBZ and STUR consume Rt; R-type consumes Rm.
        opb <= rf_read((is_cbz(imem_rdata) || is_stur(imem_rdata)) ?
                       ridx(imem_rdata[4:0]) : ridx(imem_rdata[20:16]));
      end
      if (mem_issue) begin
        dmem_addr  <= DADDR_W'(eff_addr >> 2);
        dmem_wdata <= opb;
      end
      if (rf_we && (rf_waddr != XZR)) rf[rf_waddr] <= rf_wdata;
      if (state_next == S_HALT) halted <= 1'b1;
    end
  end

`ifdef RETIRE_TRACE_EN
  assign retire_valid = retire_now && resetn;
  assign retire_pc    = pc;
`else
  assign retire_valid = 1'b0;
  assign retire_pc    = '0;
  logic unused_retire;
  assign unused_retire = retire_now;
`endif

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Bench for legv8_multicycle_core: directed programs plus a random program checked against
// an instruction-level reference model (architectural registers, memory and pc).
module tb_legv8_multicycle_core;
  localparam int CW = 512;
  localparam int DW = 512;
  localparam int PW = 9;
  localparam int AW = 9;
`ifdef RETIRE_TRACE_EN
  localparam int RET_PER = 1;
`else
  localparam int RET_PER = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          run = 1'b1;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [AW-1:0] dmem_addr;
  logic          dmem_we;
  logic [31:0]   dmem_wdata, dmem_rdata;
  logic          halted;
  logic [7:0]    dbg_pc;
  logic [2:0]    dbg_state;
  logic          retire_valid;
  logic [PW-1:0] retire_pc;

  always #5 clk = ~clk;

  legv8_multicycle_core dut (
    .clk(clk), .resetn(resetn), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .halted(halted), .dbg_pc(dbg_pc), .dbg_state(dbg_state),
    .retire_valid(retire_valid), .retire_pc(retire_pc)
  );

  // Sync-read memories with a backdoor load port used only while the core is in reset.
  logic [31:0]   imem_mem [CW];
  logic [31:0]   dmem_mem [DW];
  logic          bd_i_we = 1'b0, bd_d_we = 1'b0;
  logic [8:0]    bd_addr = '0;
  logic [31:0]   bd_data = '0;
  always @(posedge clk) begin
    imem_rdata <= imem_mem[imem_addr];
    dmem_rdata <= dmem_mem[dmem_addr];
    if (bd_i_we) imem_mem[bd_addr] <= bd_data;
    if (bd_d_we) dmem_mem[bd_addr] <= bd_data;
    else if (dmem_we) dmem_mem[dmem_addr] <= dmem_wdata;
  end

  int            we_cnt = 0, ret_cnt = 0;
  logic [PW-1:0] ret_pc_last = '0;
  always @(negedge clk) begin
    if (dmem_we) we_cnt++;
    if (retire_valid) begin
      ret_cnt++;
      ret_pc_last = retire_pc;
    end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [DW];
  logic [31:0] m_imem [CW];
  int          m_pc;

  function automatic int wrap(input int v);
    return ((v % CW) + CW) % CW;
  endfunction
  function automatic logic [31:0] m_rd(input int r);
    return (r == 31) ? 32'd0 : m_reg[r];
  endfunction
  task automatic m_wr(input int r, input logic [31:0] v);
    if (r != 31) m_reg[r] = v;
  endtask
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_pc = 0;
  endtask

  // Executes one instruction architecturally and reports its expected cycle count.
  task automatic m_step(output int lat);
    logic [31:0] w, ea;
    int rd, rn, rm, wa;
    w  = m_imem[m_pc];
    rd = int'(w[4:0]);
    rn = int'(w[9:5]);
    rm = int'(w[20:16]);
    ea = m_rd(rn) + 32'(int'($signed(w[20:12])));
    wa = int'((ea / 4) % 32'(DW));
    if (w[31:21] == 11'b10001011000) begin
      m_wr(rd, m_rd(rn) + m_rd(rm)); m_pc = wrap(m_pc + 1); lat = 3;
    end else if (w[31:21] == 11'b11001011000) begin
      m_wr(rd, m_rd(rn) - m_rd(rm)); m_pc = wrap(m_pc + 1); lat = 3;
    end else if (w[31:26] == 6'b000101) begin
      m_pc = wrap(m_pc + int'($signed(w[25:0]))); lat = 3;
    end else if (w[31:24] == 8'b10110100) begin
      m_pc = (m_rd(rd) == 0) ? wrap(m_pc + int'($signed(w[23:5]))) : wrap(m_pc + 1); lat = 3;
    end else if (w[31:21] == 11'b11111000010) begin
      m_wr(rd, m_mem[wa]); m_pc = wrap(m_pc + 1); lat = 5;
    end else if (w[31:21] == 11'b11111000000) begin
      m_mem[wa] = m_rd(rd); m_pc = wrap(m_pc + 1); lat = 4;
    end else begin
      lat = -1;
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] e_add(input int rd, input int rn, input int rm, input int sh);
    return {11'b10001011000, 5'(rm), 6'(sh), 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_sub(input int rd, input int rn, input int rm);
    return {11'b11001011000, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] e_b(input int off);
    return {6'b000101, 26'(off)};
  endfunction
  function automatic logic [31:0] e_cbz(input int rt, input int off);
    return {8'b10110100, 19'(off), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_ldur(input int rt, input int rn, input int imm);
    return {11'b11111000010, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] e_stur(input int rt, input int rn, input int imm);
    return {11'b11111000000, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] rand_insn();
    int k, a, b, c;
    k = int'($urandom_range(0, 9));
    a = int'($urandom_range(0, 31));
    b = int'($urandom_range(0, 31));
    c = int'($urandom_range(0, 31));
    case (k)
      0, 1, 2: return e_add(a, b, c, int'($urandom_range(0, 63)));
      3, 4:    return e_sub(a, b, c);
      5, 6:    return e_ldur(a, b, int'($urandom_range(0, 511)) - 256);
      7:       return e_stur(a, b, int'($urandom_range(0, 511)) - 256);
      8:       return e_b(int'($urandom_range(0, 40)) - 20);
      default: return e_cbz(a, int'($urandom_range(0, 40)) - 20);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rst_enter();
    resetn = 1'b0;
    @(negedge clk);
  endtask
  task automatic rst_leave();
    m_reset();
    resetn = 1'b1;
  endtask
  task automatic put_i(input int a, input logic [31:0] d);
    bd_i_we = 1'b1; bd_addr = 9'(a); bd_data = d; m_imem[a] = d;
    @(negedge clk);
    bd_i_we = 1'b0;
  endtask
  task automatic put_d(input int a, input logic [31:0] d);
    bd_d_we = 1'b1; bd_addr = 9'(a); bd_data = d; m_mem[a] = d;
    @(negedge clk);
    bd_d_we = 1'b0;
  endtask

  // Runs one instruction from FETCH back to FETCH, bounded to 12 cycles.
  task automatic run_step(input string tag, output int cyc);
    int lat, pc0, r0;
    pc0 = m_pc;
    r0  = ret_cnt;
    m_step(lat);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (dbg_state != 3'd0 && cyc < 12);
    check({tag, " latency"}, cyc, lat);
    check({tag, " pc"}, imem_addr, m_pc);
    check({tag, " dbg_pc"}, dbg_pc, m_pc % 256);
    check({tag, " retire count"}, ret_cnt - r0, RET_PER);
`ifdef RETIRE_TRACE_EN
    check({tag, " retire pc"}, ret_pc_last, pc0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, total, w0, r0, bad;
    m_reset();
    for (int i = 0; i < DW; i++) m_mem[i] = 32'd0;

    // Load/load/add/store sequence.
    rst_enter();
    put_d(0, 32'd5); put_d(1, 32'd7); put_d(2, 32'd0);
    put_i(0, e_ldur(1, 31, 0)); put_i(1, e_ldur(2, 31, 4));
    put_i(2, e_add(3, 1, 2, 5)); put_i(3, e_stur(3, 31, 8));
    rst_leave();
    w0 = we_cnt; total = 0;
    for (int i = 0; i < 4; i++) begin
      run_step("prog1", c);
      total += c;
    end
    check("prog1 total cycles", total, 17);
    check("prog1 we pulses", we_cnt - w0, 1);
    check("prog1 dmem[2]", dmem_mem[2], 32'd12);

    // Reset values, taken from a non-idle datapath.
    rst_enter();
    check("reset state", dbg_state, 3'd0);
    check("reset dbg_pc", dbg_pc, 8'd0);
    check("reset imem_addr", imem_addr, 0);
    check("reset halted", halted, 1'b0);
    check("reset dmem_we", dmem_we, 1'b0);
    check("reset dmem_addr", dmem_addr, 0);
    check("reset dmem_wdata", dmem_wdata, 0);

    // Unconditional branches forward/back.
    put_i(0, e_add(0, 0, 0, 0)); put_i(1, e_b(3)); put_i(4, e_b(3)); put_i(7, e_b(-3));
    rst_leave();
    run_step("b nop", c);
    run_step("b +3 at 1", c);  check("b +3 at 1 target", imem_addr, 4);
    run_step("b +3 at 4", c);  check("b +3 at 4 target", imem_addr, 7);
    run_step("b -3 at 7", c);  check("b -3 at 7 target", imem_addr, 4);

    // Wrap below zero, then a self-loop.
    rst_enter();
    put_i(0, e_b(-1)); put_i(CW - 1, e_b(0));
    rst_leave();
    run_step("b -1 at 0", c);  check("b -1 wrap target", imem_addr, CW - 1);
    for (int i = 0; i < 3; i++) run_step("b 0 loop", c);
    check("b 0 holds", imem_addr, CW - 1);

    // CBZ taken / not taken, XZR behaviour, SUB wraparound.
    rst_enter();
    put_d(0, 32'd1); put_d(3, 32'd99); put_d(4, 32'd0);
    put_i(0, e_cbz(4, 2)); put_i(2, e_ldur(4, 31, 0)); put_i(3, e_cbz(4, 2));
    put_i(4, e_ldur(1, 31, 0)); put_i(5, e_ldur(2, 31, 0));
    put_i(6, e_add(31, 1, 2, 0)); put_i(7, e_add(5, 31, 31, 0)); put_i(8, e_stur(5, 31, 12));
    put_i(9, e_sub(6, 31, 4)); put_i(10, e_stur(6, 31, 16));
    rst_leave();
    run_step("cbz zero", c);   check("cbz taken target", imem_addr, 2);
    run_step("ldur x4", c);
    run_step("cbz one", c);    check("cbz not taken target", imem_addr, 4);
    for (int i = 0; i < 7; i++) run_step("xzr/sub prog", c);
    check("xzr sum stored", dmem_mem[3], 32'd0);
    check("sub 0-1", dmem_mem[4], 32'hFFFF_FFFF);

    // Pause requested while a load is in flight.
    rst_enter();
    put_d(0, 32'h1234); put_d(6, 32'd0);
    put_i(0, e_ldur(7, 31, 0)); put_i(1, e_stur(7, 31, 24));
    rst_leave();
    r0 = ret_cnt;
    m_step(c);
    @(negedge clk);
    run = 1'b0;
    total = 1;
    do begin
      @(negedge clk);
      total++;
    end while (dbg_state != 3'd0 && total < 12);
    check("paused ldur latency", total, 5);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dbg_state != 3'd0 || imem_addr != 9'd1) bad++;
    end
    check("pause holds in fetch", bad, 0);
    check("pause retire count", ret_cnt - r0, RET_PER);
    run = 1'b1;
    run_step("stur after pause", c);
    check("paused load value", dmem_mem[6], 32'h1234);

    // Reset during MEM of a store must suppress the write.
    rst_enter();
    put_d(5, 32'h55);
    put_i(0, e_stur(31, 31, 20));
    rst_leave();
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("store reached mem", dbg_state, 3'd3);
    check("store strobe in mem", dmem_we, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    check("aborted store", dmem_mem[5], 32'h55);
    check("abort pc", dbg_pc, 8'd0);
    check("abort state", dbg_state, 3'd0);

    // Illegal opcode halts and stays halted until reset.
    put_i(0, e_add(0, 0, 0, 0)); put_i(1, 32'hFFFF_FFFF);
    rst_leave();
    run_step("pre-halt nop", c);
    total = 0;
    do begin
      @(negedge clk);
      total++;
    end while (halted !== 1'b1 && total < 3);
    check("halt latency", total, 3);
    check("halt state", dbg_state, 3'd5);
    bad = 0; w0 = we_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted !== 1'b1 || dbg_state != 3'd5 || imem_addr != 9'd1) bad++;
    end
    check("halt sticky", bad, 0);
    check("halt no stores", we_cnt - w0, 0);
    resetn = 1'b0;
    @(negedge clk);
    check("halt reset pc", dbg_pc, 8'd0);
    check("halt reset flag", halted, 1'b0);

    // Random program versus the reference model.
    for (int i = 0; i < DW; i++) put_d(i, $urandom);
    for (int i = 0; i < CW; i++) put_i(i, rand_insn());
    rst_leave();
    for (int i = 0; i < 400; i++) run_step("random", c);
    for (int i = 0; i < DW; i++) check("random dmem word", dmem_mem[i], m_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
